mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_pkg.sv | 15 +
 rtl/And.sv | 12 +
 rtl/Mux.sv | 14 +
 rtl/mux_arbiter.sv | 124 ++++++++++++
 tb/tb_mux_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester mux arbiter.
//   state_t          : FSM encoding (IDLE=0, G0=1, G1=2)
//   MAX_HOLD_DEFAULT : default limit on consecutive grant cycles while the
//                      other requester is waiting
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int MAX_HOLD_DEFAULT = 4;

endpackage

// File: rtl/And.sv
// Single-bit AND gate.
//   a, b : inputs
//   out  : a & b
module And (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a & b;

endmodule

// File: rtl/Mux.sv
// Single-bit 2:1 mux gate.
//   a, b : data inputs
//   sel  : 0 selects a, 1 selects b
//   out  : selected data
module Mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic out
);

  assign out = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter steering a shared 1-bit data path.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   req0, req1 : level requests
//   a, b       : requester data
//   gnt0, gnt1 : grants, decoded from the state register
//   sel        : mux select (1 while G1 owns the path)
//   out        : selected data, forced to 0 when nobody is granted
//   busy       : gnt0 | gnt1
//
// Handshake: a requester holds req high for as long as it wants the path;
// the grant follows one edge after req is sampled and is withdrawn one edge
// after req drops. When both request, the owner keeps the path for at most
// MAX_HOLD consecutive cycles before handing over directly to the other.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic a,
  input  logic b,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic out,
  output logic busy
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state;
  state_t          state_next;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_next;
  logic            last_grant;
  logic            mux_out;

  // State register, hold counter and tie-break memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= 1'b1;  // requester 0 wins the first tie
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      if (state_next != state && state_next == G0) begin
        last_grant <= 1'b0;
      end else if (state_next != state && state_next == G1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Next-state logic. The hold limit only matters when the other side is
  // requesting, so a lone owner is never preempted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_grant ? G0 : G1;
        end else if (req0) begin
          state_next = G0;
        end else if (req1) begin
          state_next = G1;
        end
      end
      G0: begin
        if (req0 && (!req1 || hold_cnt < HOLD_LAST)) begin
          state_next = G0;
        end else if (req1) begin
          state_next = G1;
        end else begin
          state_next = IDLE;
        end
      end
      G1: begin
        if (req1 && (!req0 || hold_cnt < HOLD_LAST)) begin
          state_next = G1;
        end else if (req0) begin
          state_next = G0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change and saturates at MAX_HOLD-1.
  always_comb begin
    hold_next = hold_cnt;
    if (state_next != state) begin
      hold_next = '0;
    end else if (busy && hold_cnt < HOLD_LAST) begin
      hold_next = hold_cnt + HW'(1);
    end
  end

  assign gnt0 = (state == G0);
  assign gnt1 = (state == G1);
  assign sel  = (state == G1);
  assign busy = gnt0 | gnt1;

  Mux u_mux (
    .a   (a),
    .b   (b),
    .sel (sel),
    .out (mux_out)
  );

  // Gate the data path so nothing leaks out while idle.
  And u_and (
    .a   (mux_out),
    .b   (busy),
    .out (out)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed testbench for mux_arbiter (MAX_HOLD = 4).
// Expected output vectors are {gnt0, gnt1, sel, busy, out}.
module tb_mux_arbiter;

  logic clk;
  logic rst;
  logic req0;
  logic req1;
  logic a;
  logic b;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic out;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  mux_arbiter #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .a    (a),
    .b    (b),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .sel  (sel),
    .out  (out),
    .busy (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, queue depth %0d", exp_q.size());
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  function automatic logic [4:0] e_idle();
    return 5'b00000;
  endfunction

  function automatic logic [4:0] e_g0(input logic d);
    return {1'b1, 1'b0, 1'b0, 1'b1, d};
  endfunction

  function automatic logic [4:0] e_g1(input logic d);
    return {1'b0, 1'b1, 1'b1, 1'b1, d};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (gnt0 gnt1 sel busy out)", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive inputs at the falling edge; the expected outputs after the next
  // rising edge go into the scoreboard queue.
  task automatic step(input logic r0, input logic r1, input logic da,
                      input logic db, input logic [4:0] exp);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    a    = da;
    b    = db;
    exp_q.push_back(exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL mutex: gnt0=%b gnt1=%b both high", gnt0, gnt1);
      end
      if (exp_q.size() > 0) begin
        chk("cycle", {gnt0, gnt1, sel, busy, out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; a = 1'b0; b = 1'b0;
    #1 rst = 1'b1;
    #2 chk("reset_state", {gnt0, gnt1, sel, busy, out}, e_idle());
    @(negedge clk);
    rst = 1'b0;

    // req0 alone: gnt0 one edge later, out follows a.
    step(1, 0, 1, 0, e_g0(1));
    step(1, 0, 0, 1, e_g0(0));
    step(0, 0, 1, 1, e_idle());

    // Fresh reset so last_grant is back to 1, then a tie.
    @(negedge clk);
    rst = 1'b1;
    #1 chk("reset_again", {gnt0, gnt1, sel, busy, out}, e_idle());
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 1, 0, e_g0(1));
    step(1, 1, 1, 0, e_g0(1));
    step(1, 1, 0, 0, e_g0(0));
    step(1, 1, 1, 0, e_g0(1));
    step(1, 1, 1, 0, e_g1(0));   // hold limit reached: direct handover

    // G1 alone for 10 cycles: never preempted.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1'(i), 1'(i + 1), e_g1(1'(i + 1)));
    end
    step(0, 0, 1, 1, e_idle());

    // G0 drops req0 while req1 waits.
    step(1, 0, 1, 0, e_g0(1));
    step(0, 1, 1, 0, e_g1(0));
    step(0, 0, 0, 0, e_idle());

    // Mirror hold limit from G1 to G0.
    step(0, 1, 0, 1, e_g1(1));
    step(1, 1, 0, 1, e_g1(1));
    step(1, 1, 0, 1, e_g1(1));
    step(1, 1, 0, 1, e_g1(1));
    step(1, 1, 1, 0, e_g0(1));
    step(0, 0, 1, 0, e_idle());
    // last_grant is now 0, so the tie goes to requester 1.
    step(1, 1, 0, 1, e_g1(1));
    step(0, 0, 0, 0, e_idle());

    // Reset between edges while G1 is active.
    step(0, 1, 0, 1, e_g1(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_mid_g1", {gnt0, gnt1, sel, busy, out}, e_idle());
    @(negedge clk);
    req0 = 1'b1;
    req1 = 1'b1;
    a    = 1'b1;
    rst  = 1'b0;
    exp_q.push_back(e_g0(1));
    step(0, 0, 0, 0, e_idle());

    // Sweep a, b, sel through the data path.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1'(i >> 1), 1'(i), e_g0(1'(i >> 1)));
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1'(i >> 1), 1'(i), e_g1(1'(i)));
    end
    step(0, 0, 1, 1, e_idle());

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
